// File: rtl/pipelined_mux_tree.sv
// Pipelined tree of registered 4:1 muxes with a pipeline-wide hold.
// Define MUX_SCAN_EN to add scan_en and a free-running channel scan counter.
module pipelined_mux_tree #(
    parameter int DATA_W = 8,
    parameter int N_CH = 16,
    localparam int LEVELS = $clog2(N_CH) / 2,
    localparam int SEL_W = 2 * LEVELS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    input  logic                   hold,
`ifdef MUX_SCAN_EN
    input  logic                   scan_en,
`endif
    output logic [DATA_W-1:0]      data_out,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid
);

    logic [SEL_W-1:0] sel_eff;
    logic             vld_eff;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_q, scan_d;

    always_comb begin
        scan_d  = scan_q;
        sel_eff = scan_en ? scan_q : sel;
        vld_eff = scan_en | in_valid;
        if (!hold) begin
            scan_d = scan_en ? scan_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end
`else
    assign sel_eff = sel;
    assign vld_eff = in_valid;
`endif

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N_IN = N_CH >> (2 * k);
        localparam int N_OUT = N_IN / 4;

        logic [N_IN*DATA_W-1:0]  src;
        logic [SEL_W-1:0]        sel_in;
        logic                    vld_in;
        logic [N_OUT*DATA_W-1:0] mux;
        logic [N_OUT*DATA_W-1:0] data_d, data_q;
        logic [SEL_W-1:0]        sel_d, sel_q;
        logic                    vld_d, vld_q;

        if (k == 0) begin : g_head
            assign src    = data_in;
            assign sel_in = sel_eff;
            assign vld_in = vld_eff;
        end else begin : g_body
            assign src    = g_lvl[k-1].data_q;
            assign sel_in = g_lvl[k-1].sel_q;
            assign vld_in = g_lvl[k-1].vld_q;
        end

        always_comb begin
            mux = '0;
            for (int j = 0; j < N_OUT; j++) begin
                mux[j*DATA_W +: DATA_W] =
                    src[(4 * j + int'(sel_in[2*k +: 2])) * DATA_W +: DATA_W];
            end
        end

        // Bubbles only clear valid; data and sel keep the last real item.
        always_comb begin
            data_d = data_q;
            sel_d  = sel_q;
            vld_d  = vld_q;
            if (!hold) begin
                vld_d = vld_in;
                if (vld_in) begin
                    data_d = mux;
                    sel_d  = sel_in;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                sel_q  <= '0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                sel_q  <= sel_d;
                vld_q  <= vld_d;
            end
        end
    end

    assign data_out  = g_lvl[LEVELS-1].data_q;
    assign out_sel   = g_lvl[LEVELS-1].sel_q;
    assign out_valid = g_lvl[LEVELS-1].vld_q;

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Directed bench for pipelined_mux_tree (16 channels x 8 bits, 2 levels).
// Scan tests are compiled in when MUX_SCAN_EN is defined.
module tb_pipelined_mux_tree;
    localparam int DW = 8;
    localparam int NC = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC*DW-1:0] data_in = '0;
    logic [SW-1:0] sel = '0;
    logic          in_valid = 1'b0;
    logic          hold = 1'b0;
`ifdef MUX_SCAN_EN
    logic          scan_en = 1'b0;
`endif
    logic [DW-1:0] data_out;
    logic [SW-1:0] out_sel;
    logic          out_valid;

    int checks = 0;
    int errors = 0;

    pipelined_mux_tree #(.DATA_W(DW), .N_CH(NC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .sel      (sel),
        .in_valid (in_valid),
        .hold     (hold),
`ifdef MUX_SCAN_EN
        .scan_en  (scan_en),
`endif
        .data_out (data_out),
        .out_sel  (out_sel),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [3:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*DW-1:0] pat(input logic [7:0] base,
                                             input logic [7:0] step);
        logic [NC*DW-1:0] p;
        logic [7:0] v;
        p = '0;
        v = base;
        for (int i = 0; i < NC; i++) begin
            p[i*DW +: DW] = v;
            v = v + step;
        end
        return p;
    endfunction

    function automatic logic [NC*DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [7:0] exp_q[16];

`ifdef MUX_SCAN_EN
    int got_sel[$];

    task automatic step_scan(input logic en, input logic h);
        scan_en = en;
        hold = h;
        tick();
        if (!h && out_valid) got_sel.push_back(int'(out_sel));
    endtask
`endif

    initial begin
        vecs[0] = '{8'h10, 8'h01, 4'd9,  8'h19};
        vecs[1] = '{8'hA0, 8'h03, 4'd0,  8'hA0};
        vecs[2] = '{8'h00, 8'h11, 4'd15, 8'hFF};
        vecs[3] = '{8'h05, 8'h02, 4'd6,  8'h11};
        vecs[4] = '{8'hF0, 8'h01, 4'd12, 8'hFC};
        vecs[5] = '{8'h80, 8'h10, 4'd3,  8'hB0};

        #12;
        chk("rst_data", data_out, 0);
        chk("rst_sel", out_sel, 0);
        chk("rst_valid", out_valid, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // single pulses, 2-cycle latency, data_in scrambled after acceptance
        for (int v = 0; v < 6; v++) begin
            data_in = pat(vecs[v].base, vecs[v].step);
            sel = vecs[v].sel;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            data_in = rnd_data();
            sel = 4'($urandom());
            tick();
            chk($sformatf("vec%0d_data", v), data_out, vecs[v].exp);
            chk($sformatf("vec%0d_sel", v), out_sel, vecs[v].sel);
            chk($sformatf("vec%0d_valid", v), out_valid, 1);
            tick();
            chk($sformatf("vec%0d_bubble", v), out_valid, 0);
            chk($sformatf("vec%0d_held", v), data_out, vecs[v].exp);
        end

        // back-to-back stream of 16
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                data_in = rnd_data();
                sel = 4'(c);
                in_valid = 1'b1;
                exp_q[c] = data_in[c*DW +: DW];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk($sformatf("stream%0d_valid", c), out_valid,
                32'((c >= 1) && (c <= 16)));
            if (c >= 1 && c <= 16) begin
                chk($sformatf("stream%0d_data", c), data_out, exp_q[c-1]);
                chk($sformatf("stream%0d_sel", c), out_sel, c - 1);
            end
        end

        // hold freezes the pipe; item offered during hold is dropped
        data_in = pat(8'h40, 8'h01);
        sel = 4'd3;
        in_valid = 1'b1;
        tick();
        sel = 4'd4;
        tick();
        chk("hold_pre_sel", out_sel, 3);
        chk("hold_pre_data", data_out, 8'h43);
        hold = 1'b1;
        sel = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_sel", i), out_sel, 3);
            chk($sformatf("hold%0d_valid", i), out_valid, 1);
        end
        hold = 1'b0;
        sel = 4'd5;
        tick();
        chk("hold_post4_sel", out_sel, 4);
        chk("hold_post4_data", data_out, 8'h44);
        in_valid = 1'b0;
        tick();
        chk("hold_post5_sel", out_sel, 5);
        chk("hold_post5_data", data_out, 8'h45);
        tick();
        chk("hold_drain_valid", out_valid, 0);

        // asynchronous reset mid-stream
        data_in = pat(8'h60, 8'h01);
        sel = 4'd2;
        in_valid = 1'b1;
        tick();
        tick();
        chk("mid_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_sel", out_sel, 0);
        chk("mid_rst_valid", out_valid, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid_post%0d_valid", i), out_valid, 0);
        end

`ifdef MUX_SCAN_EN
        // scan 18 cycles
        data_in = pat(8'h30, 8'h01);
        in_valid = 1'b0;
        scan_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 18) scan_en = 1'b0;
            tick();
            if (c >= 1 && c <= 18) begin
                chk($sformatf("scan%0d_sel", c), out_sel, (c - 1) % 16);
                chk($sformatf("scan%0d_data", c), data_out,
                    8'h30 + 8'((c - 1) % 16));
                chk($sformatf("scan%0d_valid", c), out_valid, 1);
            end
        end
        chk("scan_end_valid", out_valid, 0);

        // restart on toggle, frozen under hold
        got_sel.delete();
        for (int i = 0; i < 3; i++) step_scan(1'b1, 1'b0);
        step_scan(1'b0, 1'b0);
        step_scan(1'b1, 1'b0);
        step_scan(1'b1, 1'b0);
        step_scan(1'b1, 1'b1);
        step_scan(1'b1, 1'b1);
        step_scan(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_scan(1'b0, 1'b0);
        chk("toggle_count", got_sel.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("toggle%0d_sel", i),
                (i < got_sel.size()) ? got_sel[i] : -1, i % 3);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_mux_tree.md
PIPELINED_MUX_TREE -- requirements
Module: pipelined_mux_tree

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bit width of each channel.
REQ-002 SHALL have parameter N_CH, default 16, meaning channel count; legal values 4, 16, 64, 256.
REQ-003 SHALL derive localparam LEVELS = log4(N_CH), default 2, meaning number of registered 4:1 stages; SEL_W = 2*LEVELS.
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data_in  input  N_CH*DATA_W  packed channels; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port sel  input  SEL_W  channel index to forward.
REQ-008 SHALL have port in_valid  input  1  qualifies data_in/sel in the current cycle.
REQ-009 SHALL have port hold  input  1  freezes the whole pipeline.
REQ-010 SHALL have port data_out  output  DATA_W  selected channel data.
REQ-011 SHALL have port out_sel  output  SEL_W  index that produced data_out.
REQ-012 SHALL have port out_valid  output  1  data_out/out_sel are valid.

Function
REQ-013 SHALL build a tree of 4:1 muxes, LEVELS deep; level k (k=0 at inputs) SHALL select with sel[2k+1:2k].
REQ-014 SHALL register the output of every level; latency from sampled input to data_out SHALL be exactly LEVELS cycles.
REQ-015 SHALL pipeline the unused upper sel bits, the full sel (for out_sel) and a valid bit alongside each stage.
REQ-016 SHALL sample data_in only in the cycle of acceptance; data_in SHALL NOT need to be held afterwards.
REQ-017 With hold=0, each stage SHALL load from the previous stage every cycle; a stage loaded with valid=0 SHALL keep its previous data and clear its valid bit.
REQ-018 With hold=1, all stage registers, valid bits and the scan counter SHALL keep their values; in_valid in that cycle SHALL be ignored (item dropped).
REQ-019 Back-to-back in_valid SHALL yield back-to-back out_valid, one item per cycle, in order, no bubbles.
REQ-020 out_valid SHALL be low whenever the final stage valid bit is low; data_out then holds its last value.
REQ-021 hold deasserting SHALL resume the pipeline on the next edge with no item lost or duplicated.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear all stage data, sel and valid registers and the scan counter to 0.
REQ-023 After reset: data_out=0, out_sel=0, out_valid=0; items in flight at reset SHALL be discarded.
REQ-024 First item accepted on the first rising edge with rst_n=1 SHALL appear LEVELS cycles later.

Configuration
REQ-025 Macro MUX_SCAN_EN SHALL, when defined, add input port scan_en (1 bit) and an SEL_W-bit scan counter.
REQ-026 With MUX_SCAN_EN and scan_en=1, the counter SHALL replace sel, in_valid SHALL be treated as 1, and the counter SHALL increment each non-hold cycle, wrapping N_CH-1 -> 0.
REQ-027 With MUX_SCAN_EN and scan_en=0, the counter SHALL be cleared to 0 and sel/in_valid SHALL be used.
REQ-028 Without MUX_SCAN_EN, port scan_en and the counter SHALL be absent; behaviour per REQ-013..021 only.

Verification (N_CH=16, DATA_W=8, LEVELS=2)
REQ-029 data_in channel i = 8'h10+i, sel=4'd9, in_valid pulse 1 cycle -> 2 cycles later data_out=8'h19, out_sel=9, out_valid high 1 cycle.
REQ-030 in_valid high 16 cycles, sel=0..15, data_in changed to random after each edge -> out_valid high 16 consecutive cycles, data_out equals channel sampled at each acceptance, in order.
REQ-031 stream sel=3,4,5 with hold=1 for 3 cycles after second acceptance -> outputs frozen during hold, then 3,4,5 delivered exactly once each.
REQ-032 rst_n pulled low mid-stream between clock edges -> outputs immediately 0, out_valid=0; no stale item emerges after release.
REQ-033 MUX_SCAN_EN defined, scan_en=1 for 18 cycles -> out_sel sequence 0..15,0,1 from cycle 2, data_out matching channel each cycle.
REQ-034 MUX_SCAN_EN defined, scan_en toggled 1->0->1 -> counter restarts at 0; with hold=1 during scan the counter does not advance.
